// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - opcodes, ALU selects, FSM state encoding and IR field slices for cpu_sequencer
package cpu_seq_pkg;

  // Instruction field slices of the 12-bit {opcode, K} word
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int K_MSB   = 7;
  localparam int K_LSB   = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDK  = 4'h1;
  localparam logic [3:0] OP_LDM  = 4'h2;
  localparam logic [3:0] OP_STM  = 4'h3;
  localparam logic [3:0] OP_ADDK = 4'h4;
  localparam logic [3:0] OP_ADDM = 4'h5;
  localparam logic [3:0] OP_SUBK = 4'h6;
  localparam logic [3:0] OP_SUBM = 4'h7;
  localparam logic [3:0] OP_ANDK = 4'h8;
  localparam logic [3:0] OP_ORK  = 4'h9;
  localparam logic [3:0] OP_XORK = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // ALU select codes
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;

  // Branch conditions
  localparam logic [1:0] BR_ALWAYS = 2'd0;
  localparam logic [1:0] BR_Z      = 2'd1;
  localparam logic [1:0] BR_NZ     = 2'd2;

  // FSM state encoding
  localparam logic [2:0] ST_HALT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

endpackage

// File: rtl/cpu_seq_decode.sv
// rtl/cpu_seq_decode.sv - combinational opcode decoder for cpu_sequencer
import cpu_seq_pkg::*;

module cpu_seq_decode (
  input  logic [3:0] opcode,
  output logic [2:0] alu_sel,
  output logic       mem_sel,
  output logic       writes_acc,
  output logic       writes_ram,
  output logic       is_branch,
  output logic [1:0] br_cond,
  output logic       is_halt
);

  // Map each opcode to its datapath controls; unlisted opcodes behave as NOP
  always_comb begin
    alu_sel    = ALU_PASSB;
    mem_sel    = 1'b0;
    writes_acc = 1'b0;
    writes_ram = 1'b0;
    is_branch  = 1'b0;
    br_cond    = BR_ALWAYS;
    is_halt    = 1'b0;
    case (opcode)
      OP_LDK:  begin writes_acc = 1'b1; end
      OP_LDM:  begin writes_acc = 1'b1; mem_sel = 1'b1; end
      OP_STM:  begin writes_ram = 1'b1; end
      OP_ADDK: begin writes_acc = 1'b1; alu_sel = ALU_ADD; end
      OP_ADDM: begin writes_acc = 1'b1; alu_sel = ALU_ADD; mem_sel = 1'b1; end
      OP_SUBK: begin writes_acc = 1'b1; alu_sel = ALU_SUB; end
      OP_SUBM: begin writes_acc = 1'b1; alu_sel = ALU_SUB; mem_sel = 1'b1; end
      OP_ANDK: begin writes_acc = 1'b1; alu_sel = ALU_AND; end
      OP_ORK:  begin writes_acc = 1'b1; alu_sel = ALU_OR; end
      OP_XORK: begin writes_acc = 1'b1; alu_sel = ALU_XOR; end
      OP_JMP:  begin is_branch = 1'b1; br_cond = BR_ALWAYS; end
      OP_JZ:   begin is_branch = 1'b1; br_cond = BR_Z; end
      OP_JNZ:  begin is_branch = 1'b1; br_cond = BR_NZ; end
      OP_HLT:  begin is_halt = 1'b1; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 4-cycle FETCH/DECODE/EXEC/WB controller with run/step/halt; BREAKPOINT_EN adds PC breakpoints
import cpu_seq_pkg::*;

module cpu_sequencer #(
  parameter int IW    = 12,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [IW-1:0]    instr,
  input  logic [DW-1:0]    alu_result,
  input  logic [AW-1:0]    pc,
  input  logic [AW-1:0]    bp_addr,
  input  logic             bp_valid,
  output logic [DW-1:0]    k_out,
  output logic [2:0]       alu_sel,
  output logic             mem_sel,
  output logic             acc_we,
  output logic             ram_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             z_flag,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [IW-1:0] ir;
  logic          stop_seen;
  logic          step_mode;
  logic          bp_trip;
  logic          take_branch;
  logic          wb_stop;

  logic          writes_acc;
  logic          writes_ram;
  logic          is_branch;
  logic [1:0]    br_cond;
  logic          is_halt;

  cpu_seq_decode u_decode (
    .opcode     (ir[OPC_MSB:OPC_LSB]),
    .alu_sel    (alu_sel),
    .mem_sel    (mem_sel),
    .writes_acc (writes_acc),
    .writes_ram (writes_ram),
    .is_branch  (is_branch),
    .br_cond    (br_cond),
    .is_halt    (is_halt)
  );

  assign k_out  = ir[K_MSB:K_LSB];
  assign halted = (state == ST_HALT);

`ifdef BREAKPOINT_EN
  logic first_fetch;

  // Remember that the current FETCH came straight from HALT so a resume skips the check
  always_ff @(posedge clk) begin
    if (reset) first_fetch <= 1'b1;
    else       first_fetch <= (state == ST_HALT);
  end

  assign bp_trip = (state == ST_FETCH) && !first_fetch && bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_trip   = 1'b0;
`endif

  assign bp_hit = bp_trip && !reset;

  assign take_branch = is_branch &&
                       ((br_cond == BR_ALWAYS) ||
                        ((br_cond == BR_Z)  &&  z_flag) ||
                        ((br_cond == BR_NZ) && !z_flag));

  assign wb_stop = is_halt || stop_seen || halt_req || step_mode || !run;

  // Per-state strobes; forced low while reset aborts the instruction
  always_comb begin
    acc_we  = 1'b0;
    ram_we  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    if (!reset) begin
      case (state)
        ST_EXEC: begin
          acc_we = writes_acc;
          ram_we = writes_ram;
        end
        ST_WB: begin
          pc_load = take_branch;
          pc_inc  = !take_branch;
        end
        default: begin end
      endcase
    end
  end

  // Next-state selection for the instruction sequence
  always_comb begin
    state_nxt = ST_HALT;
    case (state)
      ST_HALT:   state_nxt = (run || step) ? ST_FETCH : ST_HALT;
      ST_FETCH:  state_nxt = bp_trip ? ST_HALT : ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = wb_stop ? ST_HALT : ST_FETCH;
      default:   state_nxt = ST_HALT;
    endcase
  end

  // State, IR, zero flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HALT;
      ir        <= '0;
      z_flag    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && !bp_trip) ir <= instr;
      if (state == ST_EXEC && writes_acc) z_flag <= (alu_result == '0);
      if (state == ST_WB) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Sticky stop request and step-entry flag, both scoped to one instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_seen <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      if (state == ST_HALT || state == ST_WB) stop_seen <= 1'b0;
      else if (halt_req)                      stop_seen <= 1'b1;
      if (state == ST_HALT) step_mode <= step && !run;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer with datapath and ISA reference model
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, halt_req, bp_valid;
  logic [11:0] instr;
  logic [7:0]  alu_result, pc, bp_addr, k_out;
  logic [2:0]  alu_sel;
  logic        mem_sel, acc_we, ram_we, pc_inc, pc_load, z_flag, halted, bp_hit;
  logic [15:0] instr_cnt;

  logic [11:0] rom      [256];
  logic [7:0]  ram      [256];
  logic [7:0]  ram_seed [256];
  logic [7:0]  w;
  logic [7:0]  alu_b;

  int total = 0;
  int bad   = 0;
  int bp_seen = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .instr(instr), .alu_result(alu_result), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .k_out(k_out), .alu_sel(alu_sel), .mem_sel(mem_sel), .acc_we(acc_we), .ram_we(ram_we),
    .pc_inc(pc_inc), .pc_load(pc_load), .z_flag(z_flag), .halted(halted), .bp_hit(bp_hit),
    .instr_cnt(instr_cnt)
  );

  // Datapath around the sequencer: ROM, ALU, PC, W and RAM
  assign instr = rom[pc];

  always_comb begin
    alu_b = mem_sel ? ram[k_out] : k_out;
    case (alu_sel)
      3'b000:  alu_result = alu_b;
      3'b001:  alu_result = w + alu_b;
      3'b010:  alu_result = w - alu_b;
      3'b011:  alu_result = w & alu_b;
      3'b100:  alu_result = w | alu_b;
      3'b101:  alu_result = w ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= 8'h00;
      w   <= 8'h00;
      ram <= ram_seed;
    end else begin
      if (pc_inc)       pc <= pc + 8'h01;
      else if (pc_load) pc <= k_out;
      if (acc_we) w <= alu_result;
      if (ram_we) ram[k_out] <= w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    do begin
      tick;
      n++;
      if (bp_hit) bp_seen++;
    end while (!halted && n < max);
    check("wait_halt", halted, 1);
  endtask

  task automatic clear_rom;
    foreach (rom[i]) rom[i] = 12'hF00;
  endtask

  function automatic int ram_sum();
    int s = 0;
    foreach (ram[i]) s += ram[i] * (i + 1);
    return s;
  endfunction

  // ISA-level interpreter: runs the ROM from PC 0 with W=0, Z=0 until HLT retires
  task automatic ref_run(output logic [7:0] ew, output logic ez, output logic [7:0] epc,
                         output int en, output int esum);
    logic [7:0] m [256];
    logic [7:0] k, nxt;
    logic [3:0] op;
    m = ram_seed; ew = 0; ez = 0; epc = 0; en = 0; esum = 0;
    for (int g = 0; g < 300; g++) begin
      op  = rom[epc][11:8];
      k   = rom[epc][7:0];
      nxt = epc + 8'h01;
      en++;
      case (op)
        4'h1: ew = k;
        4'h2: ew = m[k];
        4'h3: m[k] = ew;
        4'h4: ew = ew + k;
        4'h5: ew = ew + m[k];
        4'h6: ew = ew - k;
        4'h7: ew = ew - m[k];
        4'h8: ew = ew & k;
        4'h9: ew = ew | k;
        4'hA: ew = ew ^ k;
        4'hB: nxt = k;
        4'hC: if (ez)  nxt = k;
        4'hD: if (!ez) nxt = k;
        default: ;
      endcase
      if (op inside {[4'h1:4'h2], [4'h4:4'hA]}) ez = (ew == 8'h00);
      epc = nxt;
      if (op == 4'hF) break;
    end
    foreach (m[i]) esum += m[i] * (i + 1);
  endtask

  initial begin
    int          cyc, len, r, en, esum;
    logic [3:0]  op;
    logic [7:0]  kk, ew, epc;
    logic        ez;

    bp_addr = 8'h00; bp_valid = 1'b0;
    foreach (ram_seed[i]) ram_seed[i] = 8'h00;
    clear_rom;

    // Reset state
    do_reset;
    check("rst_halted", halted, 1);
    check("rst_z", z_flag, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst_strobes", {acc_we, ram_we, pc_inc, pc_load}, 0);
    check("rst_bp_hit", bp_hit, 0);

    // LDK 5; ADDK 7; HLT
    clear_rom;
    rom[0] = 12'h105; rom[1] = 12'h407; rom[2] = 12'hF00;
    do_reset;
    run = 1'b1;
    wait_halt(40, cyc);
    run = 1'b0;
    check("basic_cycles", cyc, 13);
    check("basic_w", w, 8'h0C);
    check("basic_cnt", instr_cnt, 3);
    check("basic_z", z_flag, 0);
    check("basic_pc", pc, 3);
    tick;
    check("basic_stays_halted", halted, 1);

    // SUBK to zero then JZ taken
    clear_rom;
    rom[0] = 12'h105; rom[1] = 12'h605; rom[2] = 12'hC20;
    do_reset;
    run = 1'b1;
    repeat (7) tick;
    check("subk_exec_acc_we", acc_we, 1);
    tick;
    check("subk_z_set", z_flag, 1);
    repeat (4) tick;
    check("jz_pc_load", pc_load, 1);
    check("jz_pc_inc", pc_inc, 0);
    check("jz_k_out", k_out, 8'h20);
    wait_halt(20, cyc);
    run = 1'b0;
    check("jz_end_pc", pc, 8'h21);
    check("jz_cnt", instr_cnt, 4);

    // Same sequence with JNZ: falls through
    clear_rom;
    rom[0] = 12'h105; rom[1] = 12'h605; rom[2] = 12'hD20;
    do_reset;
    run = 1'b1;
    repeat (12) tick;
    check("jnz_pc_inc", pc_inc, 1);
    check("jnz_pc_load", pc_load, 0);
    wait_halt(20, cyc);
    run = 1'b0;
    check("jnz_end_pc", pc, 8'h04);

    // Single-step with run low; a stray step mid-instruction is ignored
    clear_rom;
    rom[0] = 12'h401; rom[1] = 12'h402; rom[2] = 12'h403;
    do_reset;
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      tick;
      step = 1'b0;
      check("step_left_halt", halted, 0);
      cyc = 0;
      do begin
        step = (s == 2 && cyc == 1);
        tick;
        cyc++;
      end while (!halted && cyc < 10);
      step = 1'b0;
      check("step_latency", cyc, 4);
      check("step_cnt", instr_cnt, s);
      check("step_w", w, s * (s + 1) / 2);
      tick;
      check("step_stays_halted", halted, 1);
    end

    // halt_req pulse during DECODE of ADDK with run held high
    clear_rom;
    rom[0] = 12'h105; rom[1] = 12'h403; rom[2] = 12'h406;
    do_reset;
    run = 1'b1;
    repeat (6) tick;
    halt_req = 1'b1;
    tick;
    halt_req = 1'b0;
    check("hreq_acc_we", acc_we, 1);
    tick;
    check("hreq_pc_inc", pc_inc, 1);
    tick;
    check("hreq_halted", halted, 1);
    check("hreq_cnt", instr_cnt, 2);
    check("hreq_w", w, 8'h08);
    run = 1'b0;

    // Reset during EXEC of STM
    clear_rom;
    rom[0] = 12'h100; rom[1] = 12'h310;
    do_reset;
    run = 1'b1;
    repeat (7) tick;
    check("stm_pre_ram_we", ram_we, 1);
    check("stm_pre_z", z_flag, 1);
    reset = 1'b1; run = 1'b0;
    #1;
    check("stm_rst_ram_we", ram_we, 0);
    check("stm_rst_strobes", {acc_we, pc_inc, pc_load}, 0);
    tick;
    reset = 1'b0;
    check("stm_rst_halted", halted, 1);
    check("stm_rst_z", z_flag, 0);
    check("stm_rst_cnt", instr_cnt, 0);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x02 stops before fetch; resume executes it without re-triggering
    clear_rom;
    rom[0] = 12'h401; rom[1] = 12'h401; rom[2] = 12'h401;
    do_reset;
    bp_addr = 8'h02; bp_valid = 1'b1; bp_seen = 0;
    run = 1'b1;
    wait_halt(40, cyc);
    run = 1'b0;
    check("bp_pulses", bp_seen, 1);
    check("bp_cnt", instr_cnt, 2);
    check("bp_pc", pc, 8'h02);
    tick;
    run = 1'b1;
    bp_seen = 0;
    wait_halt(40, cyc);
    run = 1'b0;
    check("bp_resume_pulses", bp_seen, 0);
    check("bp_resume_cnt", instr_cnt, 4);
    check("bp_resume_w", w, 8'h03);
    bp_valid = 1'b0;
`endif

    // Random forward-branching programs against the ISA model
    for (int t = 0; t < 15; t++) begin
      clear_rom;
      len = $urandom_range(3, 12);
      for (int i = 0; i < len; i++) begin
        r  = $urandom_range(0, 14);
        kk = 8'($urandom);
        if (r >= 11 && r <= 13) begin
          op = (r == 11) ? 4'hB : (r == 12) ? 4'hC : 4'hD;
          kk = 8'($urandom_range(i + 1, len));
        end else begin
          op = (r == 14) ? 4'hE : 4'(r);
        end
        rom[i] = {op, kk};
      end
      foreach (ram_seed[i]) ram_seed[i] = 8'($urandom);
      ref_run(ew, ez, epc, en, esum);
      do_reset;
      run = 1'b1;
      wait_halt(300, cyc);
      run = 1'b0;
      check("rand_cycles", cyc, 4 * en + 1);
      check("rand_w", w, ew);
      check("rand_z", z_flag, ez);
      check("rand_pc", pc, epc);
      check("rand_cnt", instr_cnt, en);
      check("rand_ram", ram_sum(), esum);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
